// File: rtl/epcq_pkg.sv
// Shared types and constants for the EPCQ command sequencer.
package epcq_pkg;

    localparam int PAGE_BYTES_DEFAULT = 256;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_START  = 3'd1,
        RD_STREAM = 3'd2,
        WR_FILL   = 3'd3,
        WR_ISSUE  = 3'd4,
        ER_ISSUE  = 3'd5,
        WAIT_BUSY = 3'd6,
        DONE      = 3'd7
    } epcq_state_t;

    // A read/program length must be 1..page bytes.
    function automatic logic len_in_range(input logic [8:0] len, input int page);
        return (len != 9'd0) && (int'(len) <= page);
    endfunction

endpackage

// File: rtl/epcq_busy_watchdog.sv
// Busy watchdog: counts enabled cycles and flags expiry at TIMEOUT_CYCLES.
module epcq_busy_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**26
) (
    input  logic clkin,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    localparam logic [26:0] LP_LIMIT = 27'(TIMEOUT_CYCLES - 1);

    logic [26:0] r_count;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!enable) begin
            r_count <= '0;
        end else if (r_count < LP_LIMIT) begin
            r_count <= r_count + 27'd1;
        end
    end

    assign expired = enable && (r_count >= LP_LIMIT);

endmodule

// File: rtl/epcq_flash_sequencer.sv
// Host command sequencer for the EPCQ parallel-IO block (read / page program / sector erase).
// Optional busy watchdog enabled by defining EPCQ_BUSY_TIMEOUT_EN.
module epcq_flash_sequencer
    import epcq_pkg::*;
#(
    parameter int PAGE_BYTES     = PAGE_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2**26
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    output logic        cmd_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        error,
    output logic [31:0] flash_addr,
    output logic [7:0]  flash_datain,
    output logic        flash_read,
    output logic        flash_rden,
    output logic        flash_write,
    output logic        flash_wren,
    output logic        flash_shift_bytes,
    output logic        flash_sector_erase,
    output logic        flash_en4b_addr,
    input  logic [7:0]  flash_dataout,
    input  logic        flash_data_valid,
    input  logic        flash_busy,
    input  logic        flash_illegal_write,
    input  logic        flash_illegal_erase,
    output logic [2:0]  o_dbg_state
);

    epcq_state_t r_state;
    epcq_state_t w_next;
    logic [1:0]  r_op;
    logic [31:0] r_addr;
    logic [8:0]  r_len;
    logic [8:0]  r_cnt;
    logic        r_wait_min;
    logic        r_error;
    logic        r_rd_valid;
    logic [7:0]  r_rd_data;
    logic        w_accept;
    logic        w_cmd_bad;
    logic        w_last;
    logic        w_byte;
    logic        w_timeout;

`ifdef EPCQ_BUSY_TIMEOUT_EN
    logic w_wd_en;
    logic w_expired;

    assign w_wd_en = (r_state == WAIT_BUSY) || (r_state == RD_STREAM);

    epcq_busy_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clkin  (clkin),
        .reset  (reset),
        .enable (w_wd_en),
        .expired(w_expired)
    );

    assign w_timeout = w_expired;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    assign w_cmd_bad = (cmd_op == 2'b11) ||
                       ((cmd_op != OP_ERASE) && !len_in_range(cmd_len, PAGE_BYTES));
    assign w_last    = (r_cnt == (r_len - 9'd1));
    assign w_byte    = ((r_state == RD_STREAM) && flash_data_valid) ||
                       ((r_state == WR_FILL) && wr_valid);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && !flash_busy) begin
                    w_accept = 1'b1;
                    if (w_cmd_bad) begin
                        w_next = DONE;
                    end else begin
                        case (cmd_op)
                            OP_READ:  w_next = RD_START;
                            OP_PROG:  w_next = WR_FILL;
                            default:  w_next = ER_ISSUE;
                        endcase
                    end
                end
            end
            RD_START:  w_next = RD_STREAM;
            RD_STREAM: begin
                if (w_timeout) begin
                    w_next = DONE;
                end else if (flash_data_valid && w_last) begin
                    w_next = WAIT_BUSY;
                end
            end
            WR_FILL: begin
                if (wr_valid && w_last) begin
                    w_next = WR_ISSUE;
                end
            end
            WR_ISSUE:  w_next = WAIT_BUSY;
            ER_ISSUE:  w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                // r_wait_min guarantees two cycles here so the EPCQ has time to raise busy.
                if (w_timeout || (r_wait_min && !flash_busy)) begin
                    w_next = DONE;
                end
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_wait_min <= 1'b0;
            r_error    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_min <= (r_state == WAIT_BUSY);
            r_rd_valid <= (r_state == RD_STREAM) && flash_data_valid;
            if ((r_state == RD_STREAM) && flash_data_valid) begin
                r_rd_data <= flash_dataout;
            end
            if (w_accept) begin
                r_op    <= cmd_op;
                r_addr  <= cmd_addr;
                r_len   <= cmd_len;
                r_cnt   <= '0;
                r_error <= w_cmd_bad;
            end else begin
                if (w_byte) begin
                    r_cnt <= r_cnt + 9'd1;
                end
                if (w_timeout ||
                    ((r_state != IDLE) &&
                     (((r_op == OP_PROG) && flash_illegal_write) ||
                      ((r_op == OP_ERASE) && flash_illegal_erase)))) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd_ready          = (r_state == IDLE);
        wr_ready           = (r_state == WR_FILL);
        done               = (r_state == DONE);
        flash_read         = (r_state == RD_START);
        flash_rden         = (r_state == RD_START) ||
                             ((r_state == RD_STREAM) && !(flash_data_valid && w_last) && !w_timeout);
        flash_shift_bytes  = (r_state == WR_FILL) && wr_valid;
        flash_datain       = flash_shift_bytes ? wr_data : 8'h00;
        flash_write        = (r_state == WR_ISSUE);
        flash_wren         = (r_state == WR_ISSUE) || (r_state == ER_ISSUE);
        flash_sector_erase = (r_state == ER_ISSUE);
    end

    assign flash_addr      = r_addr;
    assign flash_en4b_addr = 1'b1;
    assign rd_valid        = r_rd_valid;
    assign rd_data         = r_rd_data;
    assign error           = r_error;
    assign o_dbg_state     = r_state;

endmodule

// File: doc/epcq_flash_sequencer.md
Name: epcq_flash_sequencer

Overview:
- Command sequencer directly upstream of the EPCQ parallel-IO block (ASMI parallel).
- Accepts host read, page-program and sector-erase commands from the register file.
- Translates each command into the byte-level shift_bytes/write/read/rden/sector_erase handshakes.
- Tracks busy until the flash operation completes, then reports done/error status.

Parameters:
- PAGE_BYTES, 256, maximum bytes per page-program or read command; must be a power of two.
- TIMEOUT_CYCLES, 2**26, busy watchdog limit in clkin cycles; used only with the optional feature.

Ports:
- clkin  in  1  system clock, shared with the EPCQ block.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command strobe; sampled only in IDLE.
- cmd_op  in  2  command: 00 read, 01 page program, 10 sector erase, 11 reserved.
- cmd_addr  in  32  byte address; 4-byte addressing is always used.
- cmd_len  in  9  byte count, 1..PAGE_BYTES; ignored for erase.
- cmd_ready  out  1  high in IDLE.
- wr_data  in  8  program data byte.
- wr_valid  in  1  program data strobe.
- wr_ready  out  1  high in WR_FILL.
- rd_data  out  8  read data byte.
- rd_valid  out  1  one-cycle strobe per read byte.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  sticky flag: illegal_write, illegal_erase, reserved op, bad length or timeout; cleared by the next accepted command.
- flash_addr  out  32  to EPCQ addr.
- flash_datain  out  8  to EPCQ datain.
- flash_read, flash_rden, flash_write, flash_wren, flash_shift_bytes, flash_sector_erase, flash_en4b_addr  out  1 each  to the matching EPCQ inputs.
- flash_dataout  in  8  from EPCQ dataout.
- flash_data_valid, flash_busy, flash_illegal_write, flash_illegal_erase  in  1 each  from EPCQ.

Behaviour:
- Reset values:
  - all outputs 0 except cmd_ready=1 and flash_en4b_addr=1.
  - flash_en4b_addr is held at 1 permanently after reset.
  - state = IDLE, counters = 0.
- States: IDLE, RD_START, RD_STREAM, WR_FILL, WR_ISSUE, ER_ISSUE, WAIT_BUSY, DONE.
- IDLE:
  - Ignores cmd_valid while flash_busy=1.
  - On cmd_valid with flash_busy=0, latches op/addr/len and clears error.
  - Reserved op, or cmd_len=0 or >PAGE_BYTES on read/program: sets error, goes to DONE.
  - Otherwise: op00 -> RD_START, op01 -> WR_FILL, op10 -> ER_ISSUE.
- RD_START:
  - One cycle: flash_read=1, flash_rden=1, flash_addr=latched addr.
  - Next cycle -> RD_STREAM.
- RD_STREAM:
  - flash_rden=1 until cmd_len flash_data_valid strobes have been counted.
  - Each strobe forwards flash_dataout to rd_data with rd_valid=1, one cycle latency.
  - flash_rden drops in the cycle the last strobe is seen -> WAIT_BUSY.
- WR_FILL:
  - wr_ready=1.
  - Each wr_valid cycle: flash_shift_bytes=1, flash_datain=wr_data, flash_addr=latched addr (registered, same cycle as shift).
  - Byte counter increments per strobe; after cmd_len bytes -> WR_ISSUE.
  - Gaps in wr_valid are allowed; no timeout applies in WR_FILL.
- WR_ISSUE:
  - One cycle: flash_write=1, flash_wren=1 -> WAIT_BUSY.
  - flash_illegal_write sampled anywhere up to DONE sets error.
- ER_ISSUE:
  - One cycle: flash_sector_erase=1, flash_wren=1 -> WAIT_BUSY.
  - flash_illegal_erase sets error.
- WAIT_BUSY:
  - Waits at least 2 cycles, then until flash_busy=0 -> DONE.
- DONE:
  - done=1 for exactly one cycle -> IDLE.
- Addressing: wrap-around is not performed. A page program whose addr[7:0]+len exceeds 256 is passed through; the flash wraps within the page.
- Byte counters are 9 bits and compare against the latched length.
- A cmd_valid arriving outside IDLE is dropped, not queued.
- Reset mid-operation:
  - All strobes deassert immediately (asynchronous) and the state returns to IDLE.
  - A partially filled page buffer is abandoned; the EPCQ block sees no write.

Optional Feature:
- Macro EPCQ_BUSY_TIMEOUT_EN.
- Defined:
  - A 27-bit counter runs in WAIT_BUSY and RD_STREAM.
  - Reaching TIMEOUT_CYCLES sets error, drops all strobes and goes to DONE.
- Undefined:
  - No counter; WAIT_BUSY and RD_STREAM wait indefinitely.
  - The TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Shared package epcq_pkg:
  - state enum type epcq_state_t.
  - op codes OP_READ=2'b00, OP_PROG=2'b01, OP_ERASE=2'b10.
  - PAGE_BYTES_DEFAULT.
- Sub-module epcq_busy_watchdog holds the timeout counter.
  - Instantiated only under EPCQ_BUSY_TIMEOUT_EN.
  - Interface: clkin, reset, enable, expired.

Test Plan:
- Read cmd addr 0x00010000, len 4; model returns 0xA1..0xA4 -> one RD_START cycle with flash_read=1, then four rd_valid pulses in order, done one cycle after busy falls, error=0.
- Program addr 0x00020000, len 256, wr_valid with random gaps -> exactly 256 flash_shift_bytes pulses with matching datain, then one flash_write+flash_wren cycle, done after busy deasserts.
- Sector erase addr 0x00030000; model holds busy 1000 cycles -> single flash_sector_erase cycle, done at cycle busy falls plus one, cmd_ready low throughout.
- Program with model asserting flash_illegal_write -> error=1 at done; next accepted read clears error.
- cmd_len=0 and cmd_op=11 -> no flash strobes, done pulse with error=1.
- With EPCQ_BUSY_TIMEOUT_EN and TIMEOUT_CYCLES=100, busy stuck high -> error and done at cycle ~100 of WAIT_BUSY. Separately, reset asserted mid-WR_FILL -> all strobes 0, cmd_ready=1, no flash_write seen.
